// File: rtl/latch_write_sequencer.sv
// Round-robin write sequencer for a bank of level-sensitive latch cells.
// Each write runs SETUP -> STROBE (lat_en high PULSE_CYCLES) -> HOLD, then acks the grantee.
module latch_write_sequencer #(
    parameter int NREQ         = 4,
    parameter int DW           = 8,
    parameter int AW           = 2,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       wdata,
    input  logic [NREQ*AW-1:0]       waddr,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic [DW-1:0]            lat_d,
    output logic [AW-1:0]            lat_addr,
    output logic                     lat_en
);

    localparam int          GW     = $clog2(NREQ);
    localparam int          CW     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned NREQ_U = NREQ;

    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("PULSE_CYCLES must be at least 1");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [GW-1:0]   gnt_n;
    logic [DW-1:0]   d_n;
    logic [AW-1:0]   a_n;
    logic            en_n;
    logic            busy_n;
    logic [NREQ-1:0] ack_n;
    logic            found;
    int unsigned     pick;
    int unsigned     idx;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt_id;
        d_n     = lat_d;
        a_n     = lat_addr;
        en_n    = lat_en;
        ack_n   = '0;
        found   = 1'b0;
        pick    = 0;
        idx     = 0;

        // First requester at or after the pointer, wrapping.
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = (32'(ptr) + k) % NREQ_U;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    gnt_n   = GW'(pick);
                    d_n     = wdata[pick*DW +: DW];
                    a_n     = waddr[pick*AW +: AW];
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                en_n    = 1'b1;
                cnt_n   = CW'(PULSE_CYCLES - 1);
                state_n = S_STROBE;
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    en_n          = 1'b0;
                    ack_n[gnt_id] = 1'b1;
                    state_n       = S_HOLD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                ptr_n   = GW'((32'(gnt_id) + 1) % NREQ_U);
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            gnt_id   <= '0;
            lat_d    <= '0;
            lat_addr <= '0;
            lat_en   <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            gnt_id   <= gnt_n;
            lat_d    <= d_n;
            lat_addr <= a_n;
            lat_en   <= en_n;
            ack      <= ack_n;
            busy     <= busy_n;
        end
    end

endmodule
